gcd_arbiter: RTL and testbench

Round-robin scheduler that shares one `gcd` datapath among R requesters. It accepts operand pairs through a per-requester request/grant handshake and launches the shared unit with a one-cycle start pulse. It then tracks the unit's busy flag and returns the result to the owning requester through a valid/ack handshake. A watchdog reports an error if the unit fails to finish, and a drain state makes reset safe, since the unit itself has no reset.

---
 rtl/gcd_arb_pkg.sv | 18 +
 rtl/gcd_arbiter_if.sv | 30 +++
 rtl/gcd_arbiter_rr_pick.sv | 31 +++
 rtl/gcd_arbiter.sv | 145 ++++++++++++++
 tb/tb_gcd_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gcd_arb_pkg.sv
// Shared types and default widths for the round-robin gcd arbiter.
package gcd_arb_pkg;

   localparam int N_DEF       = 8;
   localparam int R_DEF       = 4;
   localparam int LOG_R_DEF   = 2;
   localparam int TIMEOUT_DEF = 64;
   localparam int TW_DEF      = 7;

   typedef enum logic [2:0] {
      DRAIN  = 3'd0,
      IDLE   = 3'd1,
      LAUNCH = 3'd2,
      RUN    = 3'd3,
      RESP   = 3'd4
   } state_e;

endpackage

// File: rtl/gcd_arbiter_if.sv
// Requester-side handshake plus the link to the shared gcd unit.
// Handshake rules: req is held until a one-cycle req_gnt; rsp_valid is held until the owner's rsp_ack bit.
interface gcd_arbiter_if #(
   parameter int N = 8,
   parameter int R = 4
);
   logic [R-1:0]   req;
   logic [R*N-1:0] req_a;
   logic [R*N-1:0] req_b;
   logic [R-1:0]   req_gnt;
   logic [R-1:0]   rsp_valid;
   logic [N-1:0]   rsp_data;
   logic           rsp_err;
   logic [R-1:0]   rsp_ack;
   logic           gcd_start;
   logic [N-1:0]   gcd_a;
   logic [N-1:0]   gcd_b;
   logic           gcd_busy;
   logic [N-1:0]   gcd_o;

   modport slave (
      input  req, req_a, req_b, rsp_ack, gcd_busy, gcd_o,
      output req_gnt, rsp_valid, rsp_data, rsp_err, gcd_start, gcd_a, gcd_b
   );

   modport master (
      output req, req_a, req_b, rsp_ack, gcd_busy, gcd_o,
      input  req_gnt, rsp_valid, rsp_data, rsp_err, gcd_start, gcd_a, gcd_b
   );
endinterface

// File: rtl/gcd_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
   parameter int R     = 4,
   parameter int LOG_R = 2
) (
   input  logic [R-1:0]     req,
   input  logic [LOG_R-1:0] ptr,
   output logic [R-1:0]     gnt,
   output logic [LOG_R-1:0] idx,
   output logic             any
);

   logic found;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      any   = |req;
      for (int k = 0; k < R; k++) begin
         int j;
         j = (int'(ptr) + k) % R;
         if (!found && req[j]) begin
            found  = 1'b1;
            gnt[j] = 1'b1;
            idx    = LOG_R'(j);
         end
      end
   end

endmodule

// File: rtl/gcd_arbiter.sv
// Shares one gcd unit among R requesters: grant, launch, watchdog, respond.
// DRAIN guards every launch because the unit has no reset and may still be busy.
module gcd_arbiter
   import gcd_arb_pkg::*;
#(
   parameter int N       = N_DEF,
   parameter int R       = R_DEF,
   parameter int LOG_R   = LOG_R_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int TW      = TW_DEF
) (
   input  logic             clock,
   input  logic             reset_n,
   gcd_arbiter_if.slave     bus,
   output state_e           dbg_state,
   output logic [LOG_R-1:0] dbg_ptr
);

   state_e           state_q, state_d;
   logic [R-1:0]     gnt_q, gnt_d;
   logic [R-1:0]     valid_q, valid_d;
   logic [N-1:0]     data_q, data_d;
   logic             err_q, err_d;
   logic             start_q, start_d;
   logic [N-1:0]     a_q, a_d;
   logic [N-1:0]     b_q, b_d;
   logic [LOG_R-1:0] ptr_q, ptr_d;
   logic [LOG_R-1:0] owner_q, owner_d;
   logic [TW-1:0]    wd_q, wd_d;

   logic [R-1:0]     pick_gnt;
   logic [LOG_R-1:0] pick_idx;
   logic             pick_any;
   logic [R-1:0]     owner_oh;

   rr_pick #(.R(R), .LOG_R(LOG_R)) u_pick (
      .req (bus.req),
      .ptr (ptr_q),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   always_comb begin
      owner_oh           = '0;
      owner_oh[owner_q]  = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = '0;
      start_d = 1'b0;
      valid_d = valid_q;
      data_d  = data_q;
      err_d   = err_q;
      a_d     = a_q;
      b_d     = b_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      wd_d    = wd_q;

      unique case (state_q)
         DRAIN: begin
            if (!bus.gcd_busy) state_d = IDLE;
         end
         IDLE: begin
            if (pick_any && !bus.gcd_busy) begin
               a_d     = bus.req_a[int'(pick_idx)*N +: N];
               b_d     = bus.req_b[int'(pick_idx)*N +: N];
               owner_d = pick_idx;
               gnt_d   = pick_gnt;
               start_d = 1'b1;
               state_d = LAUNCH;
            end
         end
         LAUNCH: begin
            wd_d    = '0;
            state_d = RUN;
         end
         RUN: begin
            // Completion wins over the watchdog when both happen in the same cycle.
            if (!bus.gcd_busy) begin
               data_d  = bus.gcd_o;
               err_d   = 1'b0;
               valid_d = owner_oh;
               state_d = RESP;
            end else if (wd_q == TW'(TIMEOUT - 1)) begin
               data_d  = '0;
               err_d   = 1'b1;
               valid_d = owner_oh;
               state_d = RESP;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         RESP: begin
            if (bus.rsp_ack[owner_q]) begin
               valid_d = '0;
               ptr_d   = (owner_q == LOG_R'(R - 1)) ? '0 : owner_q + 1'b1;
               state_d = err_q ? DRAIN : IDLE;
            end
         end
         default: state_d = DRAIN;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= DRAIN;
         gnt_q   <= '0;
         valid_q <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
         start_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         ptr_q   <= '0;
         owner_q <= '0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         err_q   <= err_d;
         start_q <= start_d;
         a_q     <= a_d;
         b_q     <= b_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         wd_q    <= wd_d;
      end
   end

   assign bus.req_gnt   = gnt_q;
   assign bus.rsp_valid = valid_q;
   assign bus.rsp_data  = data_q;
   assign bus.rsp_err   = err_q;
   assign bus.gcd_start = start_q;
   assign bus.gcd_a     = a_q;
   assign bus.gcd_b     = b_q;
   assign dbg_state     = state_q;
   assign dbg_ptr       = ptr_q;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Bench for gcd_arbiter: behavioural gcd unit with a stuck-busy override,
// directed scenarios, and a grant/response scoreboard fed by the stimulus.
module tb_gcd_arbiter;
   import gcd_arb_pkg::*;

   localparam int N       = 8;
   localparam int R       = 4;
   localparam int LOG_R   = 2;
   localparam int TIMEOUT = 4;
   localparam int TW      = 3;

   // clock / reset
   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   gcd_arbiter_if #(.N(N), .R(R)) bus ();
   state_e           dbg_state;
   logic [LOG_R-1:0] dbg_ptr;

   gcd_arbiter #(.N(N), .R(R), .LOG_R(LOG_R), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .bus       (bus),
      .dbg_state (dbg_state),
      .dbg_ptr   (dbg_ptr)
   );

   // stimulus drivers
   logic [R-1:0]   req_v    = '0;
   logic [R-1:0]   ack_man  = '0;
   logic           ack_auto = 1'b0;
   logic           stuck    = 1'b0;
   logic           hold_req = 1'b0;
   logic [R*N-1:0] a_v      = '0;
   logic [R*N-1:0] b_v      = '0;

   // behavioural gcd unit (no reset), Euclid by remainder, zero operand gives 0
   logic         m_busy = 1'b0;
   logic         m_zero = 1'b0;
   logic [N-1:0] m_x    = '0;
   logic [N-1:0] m_y    = '0;
   logic [N-1:0] m_o    = '0;

   always @(posedge clock) begin
      if (!m_busy) begin
         if (bus.gcd_start) begin
            m_x    <= bus.gcd_a;
            m_y    <= bus.gcd_b;
            m_zero <= (bus.gcd_a == '0) || (bus.gcd_b == '0);
            m_busy <= 1'b1;
         end
      end else if (m_zero) begin
         m_busy <= 1'b0;
         m_o    <= '0;
      end else if ((m_x % m_y) == '0) begin
         m_busy <= 1'b0;
         m_o    <= m_y;
      end else begin
         m_x <= m_y;
         m_y <= m_x % m_y;
      end
   end

   assign bus.req      = req_v;
   assign bus.req_a    = a_v;
   assign bus.req_b    = b_v;
   assign bus.rsp_ack  = ack_auto ? bus.rsp_valid : ack_man;
   assign bus.gcd_busy = m_busy | stuck;
   assign bus.gcd_o    = m_o;

   // scoreboard
   logic [R+N:0] exp_q[$];
   logic [R-1:0] exp_gnt_q[$];
   int n_tests   = 0;
   int n_fail    = 0;
   int gnt_seen  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic expect_job(input int i, input logic [N-1:0] res, input logic err);
      logic [R-1:0] oh;
      oh    = '0;
      oh[i] = 1'b1;
      exp_gnt_q.push_back(oh);
      exp_q.push_back({oh, err, res});
   endtask

   task automatic set_req(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
      a_v[i*N +: N] = a;
      b_v[i*N +: N] = b;
      req_v[i]      = 1'b1;
   endtask

   // one cycle; requesters drop their request once they see their grant
   task automatic tick();
      @(negedge clock);
      if (bus.req_gnt != '0) begin
         gnt_seen++;
         if (!hold_req) req_v = req_v & ~bus.req_gnt;
      end
   endtask

   task automatic wait_start(input int budget);
      int k;
      k = 0;
      while (!bus.gcd_start && k < budget) begin tick(); k++; end
      check("wait_start", 32'(bus.gcd_start), 32'd1);
   endtask

   task automatic wait_valid(input int budget);
      int k;
      k = 0;
      while (bus.rsp_valid == '0 && k < budget) begin tick(); k++; end
      check("wait_valid", 32'(bus.rsp_valid != '0), 32'd1);
   endtask

   task automatic wait_drained(input int budget);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < budget) begin tick(); k++; end
      check("wait_drained", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic monitor();
      logic [R-1:0] prev_v;
      prev_v = '0;
      forever begin
         @(negedge clock);
         if (bus.req_gnt != '0) begin
            if (exp_gnt_q.size() == 0) check("gnt_unexpected", 32'(bus.req_gnt), 32'd0);
            else check("gnt_order", 32'(bus.req_gnt), 32'(exp_gnt_q.pop_front()));
         end
         if (bus.rsp_valid != '0 && prev_v == '0) begin
            if (exp_q.size() == 0) check("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
            else check("rsp_valid_err_data", 32'({bus.rsp_valid, bus.rsp_err, bus.rsp_data}),
                       32'(exp_q.pop_front()));
         end
         prev_v = bus.rsp_valid;
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_gnt"},   32'(bus.req_gnt),   32'd0);
      check({tag, "_valid"}, 32'(bus.rsp_valid), 32'd0);
      check({tag, "_data"},  32'(bus.rsp_data),  32'd0);
      check({tag, "_err"},   32'(bus.rsp_err),   32'd0);
      check({tag, "_start"}, 32'(bus.gcd_start), 32'd0);
      check({tag, "_a"},     32'(bus.gcd_a),     32'd0);
      check({tag, "_b"},     32'(bus.gcd_b),     32'd0);
      check({tag, "_state"}, 32'(dbg_state),     32'(DRAIN));
      check({tag, "_ptr"},   32'(dbg_ptr),       32'd0);
   endtask

   initial begin
      fork
         monitor();
         begin
            #200000;
            $display("FAIL global_timeout: simulation did not finish");
            $fatal(1, "time limit");
         end
      join_none

      // reset state
      repeat (2) @(negedge clock);
      check_all_zero("reset");
      reset_n = 1'b1;
      tick();
      tick();
      check("reset_to_idle", 32'(dbg_state), 32'(IDLE));

      // contention: req0 and req2 together, pointer at 0
      expect_job(0, 8'd7, 1'b0);
      expect_job(2, 8'd9, 1'b0);
      ack_auto = 1'b1;
      set_req(0, 8'd35, 8'd14);
      set_req(2, 8'd9, 8'd27);
      wait_drained(100);
      tick();
      ack_auto = 1'b0;
      check("contention_ptr", 32'(dbg_ptr), 32'd3);

      // single request, held response, non-owner ack ignored
      expect_job(0, 8'd6, 1'b0);
      set_req(0, 8'd12, 8'd18);
      tick();
      check("single_gnt",   32'(bus.req_gnt),   32'h1);
      check("single_start", 32'(bus.gcd_start), 32'd1);
      check("single_a",     32'(bus.gcd_a),     32'd12);
      check("single_b",     32'(bus.gcd_b),     32'd18);
      tick();
      check("single_gnt_pulse",   32'(bus.req_gnt),   32'd0);
      check("single_start_pulse", 32'(bus.gcd_start), 32'd0);
      check("single_run",         32'(dbg_state),     32'(RUN));
      wait_valid(20);
      ack_man = 4'b1110;
      tick();
      tick();
      check("single_hold_valid", 32'(bus.rsp_valid), 32'h1);
      check("single_hold_data",  32'(bus.rsp_data),  32'd6);
      ack_man = 4'b0001;
      tick();
      ack_man = '0;
      check("single_cleared", 32'(bus.rsp_valid), 32'd0);
      check("single_idle",    32'(dbg_state),     32'(IDLE));
      check("single_ptr",     32'(dbg_ptr),       32'd1);

      // zero operand finishes quickly with result 0
      begin
         int c;
         expect_job(1, 8'd0, 1'b0);
         set_req(1, 8'd0, 8'd5);
         wait_start(10);
         c = 0;
         while (bus.rsp_valid == '0 && c < 10) begin tick(); c++; end
         check("zero_latency_le3", 32'(c <= 3), 32'd1);
         ack_man = 4'b0010;
         tick();
         ack_man = '0;
         check("zero_ptr", 32'(dbg_ptr), 32'd2);
      end

      // timeout with busy stuck high, then drain blocks grants
      expect_job(2, 8'd0, 1'b1);
      set_req(2, 8'd9, 8'd27);
      wait_start(10);
      stuck = 1'b1;
      wait_valid(20);
      check("timeout_err",  32'(bus.rsp_err),  32'd1);
      check("timeout_data", 32'(bus.rsp_data), 32'd0);
      ack_man = 4'b0100;
      tick();
      ack_man = '0;
      check("timeout_drain", 32'(dbg_state), 32'(DRAIN));
      expect_job(3, 8'd7, 1'b0);
      set_req(3, 8'd35, 8'd14);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("drain_no_gnt", 32'(bus.req_gnt), 32'd0);
      end
      stuck = 1'b0;
      wait_valid(20);
      ack_man = 4'b1000;
      tick();
      ack_man = '0;
      check("after_drain_ptr", 32'(dbg_ptr), 32'd0);

      // fairness: all four hold requests, zero-latency ack
      expect_job(0, 8'd6, 1'b0);
      expect_job(1, 8'd7, 1'b0);
      expect_job(2, 8'd9, 1'b0);
      expect_job(3, 8'd0, 1'b0);
      expect_job(0, 8'd6, 1'b0);
      hold_req = 1'b1;
      ack_auto = 1'b1;
      gnt_seen = 0;
      set_req(0, 8'd12, 8'd18);
      set_req(1, 8'd35, 8'd14);
      set_req(2, 8'd9, 8'd27);
      set_req(3, 8'd0, 8'd5);
      begin
         int c;
         c = 0;
         while (gnt_seen < 5 && c < 200) begin tick(); c++; end
      end
      req_v    = '0;
      hold_req = 1'b0;
      check("fair_grant_count", 32'(gnt_seen), 32'd5);
      wait_drained(50);
      tick();
      ack_auto = 1'b0;
      check("fair_ptr", 32'(dbg_ptr), 32'd1);

      // reset while the unit is busy
      exp_gnt_q.push_back(4'b0100);
      set_req(2, 8'd12, 8'd18);
      wait_start(10);
      stuck = 1'b1;
      tick();
      tick();
      check("midrun_state", 32'(dbg_state), 32'(RUN));
      #2 reset_n = 1'b0;
      #1 check_all_zero("midrun_reset");
      tick();
      reset_n = 1'b1;
      expect_job(1, 8'd7, 1'b0);
      set_req(1, 8'd35, 8'd14);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("reset_drain_no_gnt", 32'(bus.req_gnt), 32'd0);
      end
      stuck = 1'b0;
      wait_valid(20);
      ack_man = 4'b0010;
      tick();
      ack_man = '0;

      repeat (3) tick();
      check("exp_q_empty",     32'(exp_q.size()),     32'd0);
      check("exp_gnt_q_empty", 32'(exp_gnt_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
